// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR sequencer slice: FSM state encodings,
// default widths and the value substituted for an all-zero seed.
package lfsr_pkg;

  localparam int unsigned NB_LFSR_DEF = 8;
  localparam int unsigned NB_CNT_DEF  = 16;

  localparam logic [7:0] SEED_SUBST = 8'h01;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/lfsr_period_meas.sv
// Period measurement for the LFSR sequencer: compares the generator output
// with the run seed one cycle after each step and captures the step count
// at the first return to seed. Only built with LFSR_PERIOD_MEAS_EN.
module lfsr_period_meas
  import lfsr_pkg::*;
#(
  parameter int unsigned NB_LFSR = NB_LFSR_DEF,
  parameter int unsigned NB_CNT  = NB_CNT_DEF
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [NB_LFSR-1:0] i_lfsr,
  input  logic [NB_LFSR-1:0] i_seed,
  input  logic [NB_CNT-1:0]  i_steps,
  output logic [NB_CNT-1:0]  o_period,
  output logic               o_period_valid
);

  logic              valid_d;
  logic [NB_CNT-1:0] period_q;
  logic              period_valid_q;
  logic              match;

  // i_lfsr and i_steps both reflect the step issued last cycle
  assign match = valid_d && (i_lfsr == i_seed) && !period_valid_q;

  // Track last-cycle step and capture the first match of the run
  always_ff @(posedge clk) begin
    if (i_rst) begin
      valid_d        <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      valid_d <= i_valid;
      if (i_clear) begin
        period_q       <= '0;
        period_valid_q <= 1'b0;
      end else if (match) begin
        period_q       <= i_steps;
        period_valid_q <= 1'b1;
      end
    end
  end

  assign o_period       = period_q;
  assign o_period_valid = period_valid_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Run sequencer for one generador_lfsr instance: accepts seed/length
// requests, loads the seed via soft reset, steps the generator honouring
// pause/abort, flags all-zero lock-up and (with LFSR_PERIOD_MEAS_EN defined)
// measures the sequence period.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned NB_LFSR = NB_LFSR_DEF,
  parameter int unsigned NB_CNT  = NB_CNT_DEF
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [NB_LFSR-1:0] i_req_seed,
  input  logic [NB_CNT-1:0]  i_req_len,
  input  logic               i_pause,
  input  logic               i_abort,
  output logic [NB_LFSR-1:0] o_seed,
  output logic               o_soft_reset,
  output logic               o_valid,
  input  logic [NB_LFSR-1:0] i_lfsr,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_CNT-1:0]  o_steps,
  output logic [NB_CNT-1:0]  o_period,
  output logic               o_period_valid,
  output logic               o_lockup,
  output logic               o_seed_fixed
);

  localparam logic [NB_LFSR-1:0] SEED_ONE = NB_LFSR'(SEED_SUBST);
  localparam logic [NB_CNT-1:0]  CNT_ONE  = NB_CNT'(1);

  logic [1:0]         state_q, state_d;
  logic [NB_LFSR-1:0] seed_q;
  logic [NB_CNT-1:0]  len_q;
  logic [NB_CNT-1:0]  steps_q;
  logic               lockup_q;
  logic               seed_fixed_q;

  logic accept;
  logic lfsr_zero;
  logic stop_run;
  logic step;
  logic last_step;

  assign accept    = (state_q == IDLE) && i_req_valid;
  assign lfsr_zero = (state_q == RUN) && (i_lfsr == '0);
  // abort and lock-up share priority over stepping
  assign stop_run  = (state_q == RUN) && (i_abort || lfsr_zero);
  assign step      = (state_q == RUN) && !i_pause && !stop_run;
  assign last_step = step && ((steps_q + CNT_ONE) == len_q);

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = (len_q != '0) ? RUN : DONE;
      RUN:     if (stop_run || last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and run results
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      seed_q       <= SEED_ONE;
      len_q        <= '0;
      steps_q      <= '0;
      lockup_q     <= 1'b0;
      seed_fixed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        seed_q       <= (i_req_seed == '0) ? SEED_ONE : i_req_seed;
        len_q        <= i_req_len;
        steps_q      <= '0;
        lockup_q     <= 1'b0;
        seed_fixed_q <= (i_req_seed == '0);
      end else begin
        if (step && (steps_q != len_q)) steps_q <= steps_q + CNT_ONE;
        if (lfsr_zero) lockup_q <= 1'b1;
      end
    end
  end

`ifdef LFSR_PERIOD_MEAS_EN
  lfsr_period_meas #(
    .NB_LFSR(NB_LFSR),
    .NB_CNT (NB_CNT)
  ) u_period_meas (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_clear       (accept),
    .i_valid       (step),
    .i_lfsr        (i_lfsr),
    .i_seed        (seed_q),
    .i_steps       (steps_q),
    .o_period      (o_period),
    .o_period_valid(o_period_valid)
  );
`else
  assign o_period       = '0;
  assign o_period_valid = 1'b0;
`endif

  assign o_req_ready  = (state_q == IDLE);
  assign o_soft_reset = (state_q == LOAD);
  assign o_busy       = (state_q == LOAD) || (state_q == RUN);
  assign o_done       = (state_q == DONE);
  assign o_valid      = step;
  assign o_seed       = seed_q;
  assign o_steps      = steps_q;
  assign o_lockup     = lockup_q;
  assign o_seed_fixed = seed_fixed_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: a behavioural 8-bit maximal LFSR stands in for
// the generator; expected step counts, periods and flags come from a
// run-level model driven by $urandom pause patterns.
module tb_lfsr_seq_ctrl;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [7:0]  i_req_seed;
  logic [15:0] i_req_len;
  logic        i_pause;
  logic        i_abort;
  logic [7:0]  o_seed;
  logic        o_soft_reset;
  logic        o_valid;
  logic [7:0]  i_lfsr;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_steps;
  logic [15:0] o_period;
  logic        o_period_valid;
  logic        o_lockup;
  logic        o_seed_fixed;

  logic [7:0]  gen_q = 8'h01;
  logic        force_zero;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  lfsr_seq_ctrl #(
    .NB_LFSR(8),
    .NB_CNT (16)
  ) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_seed    (i_req_seed),
    .i_req_len     (i_req_len),
    .i_pause       (i_pause),
    .i_abort       (i_abort),
    .o_seed        (o_seed),
    .o_soft_reset  (o_soft_reset),
    .o_valid       (o_valid),
    .i_lfsr        (i_lfsr),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_steps       (o_steps),
    .o_period      (o_period),
    .o_period_valid(o_period_valid),
    .o_lockup      (o_lockup),
    .o_seed_fixed  (o_seed_fixed)
  );

  // Maximal-length 8-bit generator, polynomial x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Generator stand-in: soft reset loads the seed, valid advances
  always @(posedge clk) begin
    if (o_soft_reset) gen_q <= o_seed;
    else if (o_valid) gen_q <= lfsr_next(gen_q);
  end

  assign i_lfsr = force_zero ? 8'h00 : gen_q;

  // First k in 1..n where k generator steps from s return to s, else 0
  function automatic int model_period(input logic [7:0] s, input int n);
    logic [7:0] x;
    x = s;
    for (int k = 1; k <= n; k++) begin
      x = lfsr_next(x);
      if (x == s) return k;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(o_req_ready), 1);
    check({tag, "_seed"},   32'(o_seed), 1);
    check({tag, "_sreset"}, 32'(o_soft_reset), 0);
    check({tag, "_valid"},  32'(o_valid), 0);
    check({tag, "_busy"},   32'(o_busy), 0);
    check({tag, "_done"},   32'(o_done), 0);
    check({tag, "_steps"},  32'(o_steps), 0);
    check({tag, "_period"}, 32'(o_period), 0);
    check({tag, "_pvalid"}, 32'(o_period_valid), 0);
    check({tag, "_lockup"}, 32'(o_lockup), 0);
    check({tag, "_sfixed"}, 32'(o_seed_fixed), 0);
  endtask

  // One request; abort_at/zero_at/rst_at are step counts (-1 = never)
  task automatic run(input logic [7:0] seed, input int len, input bit rand_pause,
                     input int abort_at, input int zero_at, input int rst_at);
    int         steps;
    int         budget;
    int         exp_per;
    bit         fin;
    bit         lock;
    bit         pause, ab, zf, exp_v, exp_pv;
    logic [7:0] seed_eff;
    steps    = 0;
    budget   = 0;
    fin      = 1'b0;
    lock     = 1'b0;
    seed_eff = (seed == 8'h00) ? 8'h01 : seed;

    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_seed  = seed;
    i_req_len   = 16'(len);
    #1;
    check("req_ready", 32'(o_req_ready), 1);

    @(negedge clk);
    i_req_valid = 1'b0;
    i_req_seed  = 8'($urandom);
    #1;
    check("load_sreset", 32'(o_soft_reset), 1);
    check("load_seed",   32'(o_seed), 32'(seed_eff));
    check("load_valid",  32'(o_valid), 0);
    check("load_busy",   32'(o_busy), 1);
    check("load_ready",  32'(o_req_ready), 0);

    if (len == 0) fin = 1'b1;
    while (!fin) begin
      @(negedge clk);
      if (rst_at >= 0 && steps == rst_at) begin
        i_pause    = 1'b0;
        i_abort    = 1'b0;
        force_zero = 1'b0;
        i_rst      = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) begin
          @(negedge clk);
          #1;
          check("midrst_nodone", 32'(o_done), 0);
        end
        return;
      end
      pause      = rand_pause ? 1'($urandom_range(0, 1)) : 1'b0;
      ab         = (abort_at >= 0 && steps == abort_at);
      zf         = (zero_at >= 0 && steps == zero_at);
      i_pause    = pause;
      i_abort    = ab;
      force_zero = zf;
      #1;
      exp_v = !pause && !ab && !zf;
      check("run_valid", 32'(o_valid), 32'(exp_v));
      check("run_busy",  32'(o_busy), 1);
      check("run_steps", 32'(o_steps), 32'(steps));
      if (exp_v) steps++;
      if (zf) lock = 1'b1;
      if (ab || zf || steps == len) fin = 1'b1;
      budget++;
      if (budget > 20000) begin
        check("run_timeout", 32'(budget), 20000);
        fin = 1'b1;
      end
    end

    @(negedge clk);
    i_pause    = 1'b0;
    i_abort    = 1'b0;
    force_zero = 1'b0;
    #1;
    check("done_pulse", 32'(o_done), 1);
    check("done_busy",  32'(o_busy), 0);
    check("done_ready", 32'(o_req_ready), 0);
    check("done_valid", 32'(o_valid), 0);
    check("done_steps", 32'(o_steps), 32'(steps));

`ifdef LFSR_PERIOD_MEAS_EN
    exp_per = model_period(seed_eff, steps);
    exp_pv  = (exp_per != 0);
`else
    exp_per = 0;
    exp_pv  = 1'b0;
`endif

    @(negedge clk);
    #1;
    check("idle_done",   32'(o_done), 0);
    check("idle_ready",  32'(o_req_ready), 1);
    check("res_steps",   32'(o_steps), 32'(steps));
    check("res_period",  32'(o_period), 32'(exp_per));
    check("res_pvalid",  32'(o_period_valid), 32'(exp_pv));
    check("res_lockup",  32'(o_lockup), 32'(lock));
    check("res_sfixed",  32'(o_seed_fixed), 32'(seed == 8'h00));
  endtask

  initial begin
    i_rst       = 1'b1;
    i_req_valid = 1'b0;
    i_req_seed  = 8'h00;
    i_req_len   = 16'd0;
    i_pause     = 1'b0;
    i_abort     = 1'b0;
    force_zero  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    i_rst = 1'b0;

    run(8'h1A, 600, 1'b0, -1, -1, -1);
    run(8'h7F, 100, 1'b0, -1, -1, -1);
    run(8'h00,  10, 1'b0, -1, -1, -1);
    run(8'hC3, 300, 1'b1, -1, -1, -1);
    run(8'h55, 200, 1'b0, 40, -1, -1);
    run(8'h21, 200, 1'b0, -1, -1, 50);
    run(8'h21,  20, 1'b0, -1, -1, -1);
    run(8'h99,  50, 1'b0, -1,  5, -1);
    run(8'h44,  30, 1'b0,  7,  7, -1);
    run(8'h3C,   0, 1'b0, -1, -1, -1);
    run(8'h01, 255, 1'b0, -1, -1, -1);
    run(8'hE7,  10, 1'b0,  0, -1, -1);
    for (int i = 0; i < 4; i++) begin
      run(8'($urandom), int'($urandom_range(1, 400)), 1'b1, -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
- Sequencer that owns one `generador_lfsr` instance and drives its `i_seed`, `i_soft_reset` and `i_valid`.
- Accepts run requests (seed + step count) over a valid/ready handshake, loads the seed, then steps the generator for the requested number of cycles, honouring a pause input.
- Measures the sequence period (first return to seed) and flags all-zero lock-up.
- Sits between the test/config logic and the LFSR datapath.

Parameters:
- NB_LFSR, 8, width of seed and LFSR output.
- NB_CNT, 16, width of step counter, run length and period result.

Ports:
- clk  input  1  system clock.
- i_rst  input  1  synchronous, active-high reset.
- i_req_valid  input  1  run request valid.
- o_req_ready  output  1  controller can accept a request.
- i_req_seed  input  NB_LFSR  seed for the run.
- i_req_len  input  NB_CNT  number of generator steps to issue.
- i_pause  input  1  suppresses stepping while high (RUN only).
- i_abort  input  1  terminates the current run.
- o_seed  output  NB_LFSR  to generator `i_seed`.
- o_soft_reset  output  1  to generator `i_soft_reset`.
- o_valid  output  1  to generator `i_valid`.
- i_lfsr  input  NB_LFSR  from generator `o_LFSR`.
- o_busy  output  1  run in progress (LOAD or RUN).
- o_done  output  1  one-cycle pulse at end of run.
- o_steps  output  NB_CNT  steps issued in the last or current run.
- o_period  output  NB_CNT  measured period.
- o_period_valid  output  1  o_period holds a measurement for this run.
- o_lockup  output  1  sticky: generator read all-zero during RUN.
- o_seed_fixed  output  1  sticky: zero seed was substituted.

Behaviour:
- Reset (i_rst sampled high at a clk edge):
  - State IDLE.
  - All outputs 0, except o_req_ready=1 and o_seed=1 (NB_LFSR'h01).
  - Reset mid-run aborts the run immediately; no o_done.
- FSM states: IDLE, LOAD, RUN, DONE. The state register is the only control state.
- IDLE:
  - o_req_ready=1.
  - Handshake (i_req_valid & o_req_ready) latches seed and length.
  - A latched seed of 0 is replaced by 1 and sets o_seed_fixed.
  - Accept clears o_steps, o_period, o_period_valid, o_lockup and o_seed_fixed (o_seed_fixed is then set if applicable); next state LOAD.
- LOAD:
  - Exactly one cycle, o_soft_reset=1, o_seed=latched seed, o_valid=0.
  - Next state RUN if len≠0, else DONE.
- RUN:
  - o_valid = ~i_pause.
  - The step counter increments on every cycle with o_valid=1, and o_steps follows it.
  - When o_steps+1 == len with o_valid=1, that is the final step; next state DONE.
  - i_abort high takes precedence over stepping: o_valid=0 that cycle, next state DONE.
- Period detect:
  - i_lfsr is compared with the seed on cycles where the previous cycle had o_valid=1.
  - On the first match in a run: o_period <= o_steps (registered count, aligned with i_lfsr) and o_period_valid <= 1.
  - Later matches are ignored.
- Lock-up:
  - If i_lfsr == 0 on any RUN cycle after LOAD, set o_lockup; next state DONE (same priority as abort).
  - Abort and lock-up in the same cycle: both take effect, single DONE.
- DONE:
  - o_done=1 for one cycle, o_busy=0; next state IDLE.
  - o_req_ready stays 0 in DONE, so there is no back-to-back accept.
- o_busy=1 in LOAD and RUN only.
- Results (o_steps, o_period, o_period_valid, o_lockup, o_seed_fixed) hold until the next accept.
- The step counter saturates at len and never wraps.
- Requests during LOAD/RUN/DONE are not accepted; the requester holds them.

Optional Feature:
- Macro LFSR_PERIOD_MEAS_EN.
- Defined: period comparator and o_period/o_period_valid logic as above.
- Undefined: the comparator is removed; o_period=0 and o_period_valid=0 at all times. Lock-up detection and all other behaviour are unchanged.

Decomposition:
- Shared package `lfsr_pkg`: state encoding constants (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3), default widths NB_LFSR=8 and NB_CNT=16, SEED_SUBST=8'h01.
- One natural sub-module: `lfsr_period_meas` (comparator + first-match capture), instantiated only under LFSR_PERIOD_MEAS_EN.
- The FSM and step counter stay in the top.

Test Plan:
- Reset then request seed=8'h1A, len=600, no pause → o_soft_reset one cycle with o_seed=8'h1A; 600 o_valid cycles; o_done pulse; o_steps=600; o_period=255 with o_period_valid=1 (maximal 8-bit generator).
- Seed=8'h7F, len=100 → o_done after 100 steps; o_period_valid=0; o_lockup=0.
- Seed=8'h00, len=10 → o_seed=8'h01 during LOAD; o_seed_fixed=1; 10 steps; no lock-up.
- len=300 with i_pause toggling pseudo-randomly (~50%) → o_steps=300 exactly; o_valid never high while i_pause=1; o_period=255.
- i_abort asserted at step 40 of len=200 → o_valid low from that cycle; o_done next cycle; o_steps=40.
- i_rst pulsed mid-RUN at step 50 → outputs return to reset values next cycle; no o_done; the next request runs normally. Force i_lfsr=0 in RUN → o_lockup=1 and o_done.
